mcbsp_frame_engine: RTL
=======================

MCBSP_FRAME_ENGINE -- requirements
Module: mcbsp_frame_engine

Interface
REQ-001 Parameters SHALL be: NUM_WORDS, default 8, words per frame (1..16); BITS_PER_WORD, default 32, bits per word (8..32); SAXIS_TDATA_WIDTH, default 32, width of each input word, with only the low BITS_PER_WORD bits used.
REQ-002 The design SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be:
- a_clk  in  1  system clock; must run at least 8x mcbsp_clk.
- a_resetn  in  1  asynchronous active-low reset.
- mcbsp_clk  in  1  McBSP bit clock; sampled as data, never used as a clock.
- mcbsp_frame_start  in  1  frame sync.
- mcbsp_data_rx  in  1  serial receive line.
- mcbsp_data_tx  out  1  serial transmit line.
- mcbsp_data_clkr  out  1  synchronised bit-clock return.
- mcbsp_data_fsx  out  1  one-cycle frame-start pulse.
- mcbsp_data_frm  out  1  high while a frame is being shifted.
- trigger  out  1  same pulse as mcbsp_data_fsx.
- S_AXIS_tdata  in  NUM_WORDS*SAXIS_TDATA_WIDTH  transmit words; word 0 is in the top slice.
- S_AXIS_tvalid  in  NUM_WORDS  per-word valid.
- M_AXIS_tdata  out  BITS_PER_WORD  received word.
- M_AXIS_tvalid  out  1  received-word valid.
- M_AXIS_tready  in  1  received-word ready.
- M_AXIS_tlast  out  1  marks the last word of a frame.
- frame_count  out  16  number of completed frames.
- overrun_count  out  16  number of dropped receive frames.

Function
REQ-004 mcbsp_clk, mcbsp_frame_start and mcbsp_data_rx SHALL each pass through a 2-FF synchroniser plus one history FF; rise and fall SHALL be detected from synchronised stages 2 and 3.
REQ-005 mcbsp_data_clkr SHALL equal synchronised stage 2 of mcbsp_clk.
REQ-006 The shift FSM SHALL have two states:
- IDLE: on a detected fall of mcbsp_clk while synchronised frame_start is 1, go to SHIFT, load the bit counter with N-1 (N = NUM_WORDS*BITS_PER_WORD), and pulse fsx/trigger for exactly one a_clk cycle.
- SHIFT: leave for IDLE after the bit at index 0 is sampled.
REQ-007 On the IDLE-to-SHIFT transition, each word k with S_AXIS_tvalid[k]=1 SHALL be latched into the tx register; a word with valid 0 SHALL keep its previous value.
REQ-008 In SHIFT, each detected rise of mcbsp_clk SHALL drive tx with bit [counter] on the next a_clk cycle, MSB first, word 0 first.
REQ-009 In SHIFT, each detected fall of mcbsp_clk SHALL store synchronised rx into rx bit [counter] and then decrement the counter.
REQ-010 frame_start pulses seen while in SHIFT SHALL be ignored.
REQ-011 mcbsp_data_frm SHALL be 1 exactly while the FSM is in SHIFT.
REQ-012 At frame completion, frame_count SHALL increment, wrapping modulo 2^16.
REQ-013 At frame completion, if the output buffer is empty, the rx register SHALL be copied into it.
REQ-014 At frame completion, if the output buffer is not empty, the frame SHALL be dropped and overrun_count SHALL increment, saturating at 0xFFFF.
REQ-015 The output FSM SHALL present buffered words 0..NUM_WORDS-1, one per tvalid&tready handshake.
REQ-016 Output timing: tvalid SHALL assert the cycle after the buffer loads, tlast SHALL be set only on word NUM_WORDS-1, and tdata/tvalid SHALL stay stable while tready=0.
REQ-017 The buffer SHALL become empty on the handshake of the last word; a frame completing in that same cycle SHALL be accepted without an overrun.
REQ-018 Bit-counter width SHALL be $clog2(N); word selection SHALL use counter/BITS_PER_WORD.

Reset
REQ-019 While a_resetn=0, all of the following SHALL be 0: tx, fsx, trigger, frm, M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata, frame_count, overrun_count.
REQ-020 While a_resetn=0, both FSMs SHALL be idle, the buffer empty, the synchronisers cleared and the tx/rx registers cleared.
REQ-021 A reset during SHIFT SHALL abort the frame with no count change; after release, the first frame start is detected normally.

Configuration
REQ-022 With LOOPBACK_EN defined: the rx sample SHALL come from the internal tx register (value at the prior rise), mcbsp_data_rx SHALL be ignored, and mcbsp_data_tx SHALL be held at 0.
REQ-023 With LOOPBACK_EN undefined: the rx sample SHALL come from the synchronised mcbsp_data_rx, and no loopback logic SHALL exist.

Verification
REQ-024 Defaults, a_clk at 10x mcbsp_clk, tdata words 0x11111111..0x88888888 all valid, rx driven with 0xA5A5A5A5 per word -> tx shows the 256 bits MSB first; M_AXIS delivers 8 words of 0xA5A5A5A5 with tlast on word 8; frame_count=1.
REQ-025 Only S_AXIS_tvalid[3]=1 in the second frame, word 3 changed to 0xDEADBEEF -> tx carries the first frame's words with word 3 = 0xDEADBEEF.
REQ-026 tready held 0, then two more frames -> overrun_count=2; the first frame's data is still presented unchanged.
REQ-027 a_resetn pulsed low at bit 100 of a frame -> all outputs 0; the next frame completes correctly with frame_count=1.
REQ-028 LOOPBACK_EN defined, tx words 0x01234567.. -> M_AXIS returns identical words; mcbsp_data_tx stays 0.
REQ-029 NUM_WORDS=3, BITS_PER_WORD=16 -> 48-bit frame; tlast on the third word; a frame_start asserted mid-frame is ignored.

Source files
------------

// File: rtl/mcbsp_frame_engine.sv
// McBSP frame engine: shifts a NUM_WORDS x BITS_PER_WORD frame out on the bit clock and streams received words on AXI-S.
// Build option LOOPBACK_EN: rx samples the internal tx bit and mcbsp_data_tx is held low.
module mcbsp_frame_engine #(
  parameter int unsigned NUM_WORDS         = 8,
  parameter int unsigned BITS_PER_WORD     = 32,
  parameter int unsigned SAXIS_TDATA_WIDTH = 32
) (
  input  logic                                   a_clk,
  input  logic                                   a_resetn,
  input  logic                                   mcbsp_clk,
  input  logic                                   mcbsp_frame_start,
  input  logic                                   mcbsp_data_rx,
  output logic                                   mcbsp_data_tx,
  output logic                                   mcbsp_data_clkr,
  output logic                                   mcbsp_data_fsx,
  output logic                                   mcbsp_data_frm,
  output logic                                   trigger,
  input  logic [NUM_WORDS*SAXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic [NUM_WORDS-1:0]                   S_AXIS_tvalid,
  output logic [BITS_PER_WORD-1:0]               M_AXIS_tdata,
  output logic                                   M_AXIS_tvalid,
  input  logic                                   M_AXIS_tready,
  output logic                                   M_AXIS_tlast,
  output logic [15:0]                            frame_count,
  output logic [15:0]                            overrun_count
);

  localparam int unsigned N  = NUM_WORDS * BITS_PER_WORD;
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned BW = $clog2(BITS_PER_WORD);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;
  localparam logic [0:0] O_IDLE  = 1'b0;
  localparam logic [0:0] O_SEND  = 1'b1;

  logic [2:0]               clk_sync_q, clk_sync_d;
  logic [2:0]               fs_sync_q, fs_sync_d;
  logic [2:0]               rx_sync_q, rx_sync_d;
  logic [0:0]               shift_state_q, shift_state_d;
  logic [0:0]               out_state_q, out_state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BITS_PER_WORD-1:0] tx_q [NUM_WORDS];
  logic [BITS_PER_WORD-1:0] tx_d [NUM_WORDS];
  logic [BITS_PER_WORD-1:0] rx_q [NUM_WORDS];
  logic [BITS_PER_WORD-1:0] rx_d [NUM_WORDS];
  logic [BITS_PER_WORD-1:0] buf_q [NUM_WORDS];
  logic [BITS_PER_WORD-1:0] buf_d [NUM_WORDS];
  logic                     tx_bit_q, tx_bit_d;
  logic                     fsx_q, fsx_d;
  logic [WW-1:0]            widx_q, widx_d;
  logic [BITS_PER_WORD-1:0] tdata_q, tdata_d;
  logic                     tvalid_q, tvalid_d;
  logic                     tlast_q, tlast_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;
  logic [15:0]              ovr_q, ovr_d;

  logic          clk_rise, clk_fall, rx_bit, frame_done, hs, last_hs;
  logic [WW-1:0] cnt_word;
  logic [BW-1:0] cnt_bit;

  // Edges come from the 2nd/3rd synchroniser stages; counter maps to (word, bit).
  assign clk_rise = clk_sync_q[1] & ~clk_sync_q[2];
  assign clk_fall = ~clk_sync_q[1] & clk_sync_q[2];
  assign cnt_word = WW'(NUM_WORDS - 1 - 32'(cnt_q) / BITS_PER_WORD);
  assign cnt_bit  = BW'(32'(cnt_q) % BITS_PER_WORD);
  assign hs       = tvalid_q & M_AXIS_tready;
  assign last_hs  = hs && (widx_q == WW'(NUM_WORDS - 1));

`ifdef LOOPBACK_EN
  assign rx_bit        = tx_bit_q;
  assign mcbsp_data_tx = 1'b0;
  logic unused_c;
  assign unused_c = ^{fs_sync_q[2], rx_sync_q, S_AXIS_tdata};
`else
  assign rx_bit        = rx_sync_q[1];
  assign mcbsp_data_tx = tx_bit_q;
  logic unused_c;
  assign unused_c = ^{fs_sync_q[2], rx_sync_q[2], S_AXIS_tdata};
`endif

  always_comb begin
    clk_sync_d    = {clk_sync_q[1:0], mcbsp_clk};
    fs_sync_d     = {fs_sync_q[1:0], mcbsp_frame_start};
    rx_sync_d     = {rx_sync_q[1:0], mcbsp_data_rx};
    shift_state_d = shift_state_q;
    out_state_d   = out_state_q;
    cnt_d         = cnt_q;
    tx_d          = tx_q;
    rx_d          = rx_q;
    buf_d         = buf_q;
    tx_bit_d      = tx_bit_q;
    fsx_d         = 1'b0;
    widx_d        = widx_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    frame_cnt_d   = frame_cnt_q;
    ovr_d         = ovr_q;
    frame_done    = 1'b0;

    // Shift FSM: frame sync is qualified by a bit-clock fall; start-of-frame ignored while shifting.
    case (shift_state_q)
      S_IDLE: begin
        if (clk_fall && fs_sync_q[1]) begin
          shift_state_d = S_SHIFT;
          cnt_d         = CW'(N - 1);
          fsx_d         = 1'b1;
          for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (S_AXIS_tvalid[k]) begin
              tx_d[k] = S_AXIS_tdata[(NUM_WORDS - 1 - k) * SAXIS_TDATA_WIDTH +: BITS_PER_WORD];
            end
          end
        end
      end
      default: begin
        if (clk_rise) begin
          tx_bit_d = tx_q[cnt_word][cnt_bit];
        end
        if (clk_fall) begin
          rx_d[cnt_word][cnt_bit] = rx_bit;
          if (cnt_q == '0) begin
            shift_state_d = S_IDLE;
            frame_done    = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
    endcase

    // Output FSM: buffer is full exactly while in O_SEND.
    if (hs) begin
      if (last_hs) begin
        out_state_d = O_IDLE;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
      end else begin
        widx_d  = widx_q + 1'b1;
        tdata_d = buf_q[widx_q + 1'b1];
        tlast_d = (widx_q + 1'b1) == WW'(NUM_WORDS - 1);
      end
    end

    // A frame finishing on the last-word handshake still finds the buffer free.
    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if ((out_state_q == O_IDLE) || last_hs) begin
        buf_d       = rx_d;
        out_state_d = O_SEND;
        widx_d      = '0;
        tdata_d     = rx_d[0];
        tvalid_d    = 1'b1;
        tlast_d     = (NUM_WORDS == 1);
      end else if (ovr_q != 16'hFFFF) begin
        ovr_d = ovr_q + 16'd1;
      end
    end
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      clk_sync_q    <= '0;
      fs_sync_q     <= '0;
      rx_sync_q     <= '0;
      shift_state_q <= S_IDLE;
      out_state_q   <= O_IDLE;
      cnt_q         <= '0;
      for (int unsigned k = 0; k < NUM_WORDS; k++) begin
        tx_q[k]  <= '0;
        rx_q[k]  <= '0;
        buf_q[k] <= '0;
      end
      tx_bit_q    <= 1'b0;
      fsx_q       <= 1'b0;
      widx_q      <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      frame_cnt_q <= '0;
      ovr_q       <= '0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      fs_sync_q     <= fs_sync_d;
      rx_sync_q     <= rx_sync_d;
      shift_state_q <= shift_state_d;
      out_state_q   <= out_state_d;
      cnt_q         <= cnt_d;
      tx_q          <= tx_d;
      rx_q          <= rx_d;
      buf_q         <= buf_d;
      tx_bit_q      <= tx_bit_d;
      fsx_q         <= fsx_d;
      widx_q        <= widx_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      frame_cnt_q   <= frame_cnt_d;
      ovr_q         <= ovr_d;
    end
  end

  assign mcbsp_data_clkr = clk_sync_q[1];
  assign mcbsp_data_fsx  = fsx_q;
  assign trigger         = fsx_q;
  assign mcbsp_data_frm  = (shift_state_q == S_SHIFT);
  assign M_AXIS_tdata    = tdata_q;
  assign M_AXIS_tvalid   = tvalid_q;
  assign M_AXIS_tlast    = tlast_q;
  assign frame_count     = frame_cnt_q;
  assign overrun_count   = ovr_q;

endmodule
